uart_cmd_bridge: RTL and testbench

UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

---
 rtl/uart_cmd_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_bridge.sv
// UART byte-stream to BRAM command bridge with readback serialisation.
// Define UART_CMD_TIMEOUT_EN to abort a read after WAIT_LIMIT idle cycles.
module uart_cmd_bridge #(
  parameter int PSIZE      = 64,
  parameter int WAIT_LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             cmd_valid,
  output logic             cmd_wen,
  output logic [13:0]      cmd_addr,
  output logic [PSIZE-1:0] cmd_data,
  input  logic             rd_valid,
  input  logic [PSIZE-1:0] rd_data,
  output logic             busy,
  output logic             err_timeout
);

  localparam int NBYTES = PSIZE / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [2:0] HDR0    = 3'd0;
  localparam logic [2:0] HDR1    = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] ISSUE   = 3'd3;
  localparam logic [2:0] WAIT_RD = 3'd4;
  localparam logic [2:0] TX      = 3'd5;

  // Reject payload widths that cannot be framed as whole bytes.
  if ((PSIZE % 8) != 0 || PSIZE < 8 || WAIT_LIMIT < 1) begin : g_bad_param
    $error("uart_cmd_bridge: PSIZE must be a positive multiple of 8 and WAIT_LIMIT >= 1");
  end

  logic [2:0]       state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             wen_r, wen_s;
  logic [13:0]      addr_r, addr_s;
  logic [PSIZE-1:0] data_r, data_s;
  logic [PSIZE-1:0] shift_r, shift_s;
  logic [7:0]       txd_r, txd_s;
  logic             rx_ready_r, tx_valid_r, cmd_valid_r, busy_r;
  logic             rx_fire_s, tx_fire_s;
  logic [PSIZE+7:0] rx_cat_s, tx_cat_s;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(WAIT_LIMIT + 1);
  logic [TW-1:0] timer_r, timer_s;
  logic          err_r, err_s;
`endif

  assign rx_fire_s = rx_valid & rx_ready_r;
  assign tx_fire_s = tx_valid_r & tx_ready;
  // Payload bytes enter at the LSB end; readback bytes leave from the MSB end.
  assign rx_cat_s  = {data_r, rx_data};
  assign tx_cat_s  = {shift_r, 8'h00};

  // Next-state and datapath update for the frame parser and response serialiser.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    wen_s   = wen_r;
    addr_s  = addr_r;
    data_s  = data_r;
    shift_s = shift_r;
    txd_s   = txd_r;
`ifdef UART_CMD_TIMEOUT_EN
    timer_s = {TW{1'b0}};
    err_s   = 1'b0;
`endif
    case (state_r)
      HDR0: begin
        if (rx_fire_s) begin
          wen_s   = rx_data[7];
          addr_s  = {rx_data[5:0], addr_r[7:0]};
          state_s = HDR1;
        end else begin
          state_s = HDR0;
        end
      end
      HDR1: begin
        if (rx_fire_s) begin
          addr_s  = {addr_r[13:8], rx_data};
          cnt_s   = {CW{1'b0}};
          state_s = wen_r ? DATA : ISSUE;
        end else begin
          state_s = HDR1;
        end
      end
      DATA: begin
        if (rx_fire_s) begin
          data_s = rx_cat_s[PSIZE-1:0];
          if (cnt_r == CW'(NBYTES - 1)) begin
            state_s = ISSUE;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          state_s = DATA;
        end
      end
      ISSUE: begin
        if (!wen_r && addr_r[13]) begin
          state_s = WAIT_RD;
        end else begin
          state_s = HDR0;
        end
      end
      WAIT_RD: begin
        if (rd_valid) begin
          shift_s = rd_data;
          txd_s   = rd_data[PSIZE-1 -: 8];
          cnt_s   = {CW{1'b0}};
          state_s = TX;
        end
`ifdef UART_CMD_TIMEOUT_EN
        else if (timer_r == TW'(WAIT_LIMIT - 1)) begin
          err_s   = 1'b1;
          state_s = HDR0;
        end else begin
          timer_s = timer_r + TW'(1);
        end
`else
        else begin
          state_s = WAIT_RD;
        end
`endif
      end
      TX: begin
        if (tx_fire_s) begin
          shift_s = tx_cat_s[PSIZE-1:0];
          txd_s   = tx_cat_s[PSIZE-1 -: 8];
          if (cnt_r == CW'(NBYTES - 1)) begin
            state_s = HDR0;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          state_s = TX;
        end
      end
      default: state_s = HDR0;
    endcase
  end

  // State registers; handshake flags are decoded from the next state so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= HDR0;
      cnt_r       <= {CW{1'b0}};
      wen_r       <= 1'b0;
      addr_r      <= 14'h0000;
      data_r      <= {PSIZE{1'b0}};
      shift_r     <= {PSIZE{1'b0}};
      txd_r       <= 8'h00;
      rx_ready_r  <= 1'b1;
      tx_valid_r  <= 1'b0;
      cmd_valid_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      timer_r     <= {TW{1'b0}};
      err_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      wen_r       <= wen_s;
      addr_r      <= addr_s;
      data_r      <= data_s;
      shift_r     <= shift_s;
      txd_r       <= txd_s;
      rx_ready_r  <= (state_s == HDR0) || (state_s == HDR1) || (state_s == DATA);
      tx_valid_r  <= (state_s == TX);
      cmd_valid_r <= (state_s == ISSUE);
      busy_r      <= (state_s != HDR0);
`ifdef UART_CMD_TIMEOUT_EN
      timer_r     <= timer_s;
      err_r       <= err_s;
`endif
    end
  end

  assign rx_ready  = rx_ready_r;
  assign tx_valid  = tx_valid_r;
  assign tx_data   = txd_r;
  assign cmd_valid = cmd_valid_r;
  assign cmd_wen   = wen_r;
  assign cmd_addr  = addr_r;
  assign cmd_data  = data_r;
  assign busy      = busy_r;
`ifdef UART_CMD_TIMEOUT_EN
  assign err_timeout = err_r;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench for uart_cmd_bridge: directed frames plus a randomized
// sequence compared against a frame-level reference model.
module tb_uart_cmd_bridge;

  localparam int PSIZE = 64;
  localparam int NB    = PSIZE / 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0]       rx_data, tx_data;
  logic             cmd_valid, cmd_wen, rd_valid, busy, err_timeout;
  logic [13:0]      cmd_addr;
  logic [PSIZE-1:0] cmd_data, rd_data;

  int checks = 0;
  int passed = 0;
  int txmode = 0;

  logic             mon_wen_q[$];
  logic [13:0]      mon_addr_q[$];
  logic [PSIZE-1:0] mon_data_q[$];
  logic [7:0]       mon_tx_q[$];
  int               stall_err = 0;
  int               err_cnt   = 0;
  int               wide_cmd  = 0;
  logic             prev_stall = 1'b0;
  logic             prev_cmd   = 1'b0;
  logic [7:0]       prev_txd   = 8'h00;

  always #5 clk = ~clk;

  uart_cmd_bridge #(.PSIZE(PSIZE), .WAIT_LIMIT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .cmd_valid(cmd_valid), .cmd_wen(cmd_wen), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  // Passive monitor on the falling edge: records commands, sent bytes and protocol slips.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) begin
        mon_wen_q.push_back(cmd_wen);
        mon_addr_q.push_back(cmd_addr);
        mon_data_q.push_back(cmd_data);
      end
      if (tx_valid && tx_ready) mon_tx_q.push_back(tx_data);
      if (prev_stall && tx_data !== prev_txd) stall_err <= stall_err + 1;
      if (cmd_valid && prev_cmd) wide_cmd <= wide_cmd + 1;
      if (err_timeout) err_cnt <= err_cnt + 1;
      prev_stall <= tx_valid && !tx_ready;
      prev_txd   <= tx_data;
      prev_cmd   <= cmd_valid;
    end else begin
      prev_stall <= 1'b0;
      prev_cmd   <= 1'b0;
    end
  end

  // Transmitter back-pressure: always ready, toggling, or random.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (txmode)
        1:       tx_ready = ~tx_ready;
        2:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready) chk("rx_accept_timeout", 64'(rx_ready), 64'd1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic w, input logic [13:0] a, input logic [63:0] d,
                            input logic rsvd, input logic gaps);
    send_byte({w, rsvd, a[13:8]});
    if (gaps) repeat ($urandom_range(0, 2)) step();
    send_byte(a[7:0]);
    if (w) begin
      for (int i = NB - 1; i >= 0; i--) begin
        if (gaps) repeat ($urandom_range(0, 2)) step();
        send_byte(d[i*8 +: 8]);
      end
    end
  endtask

  // Called in the ISSUE cycle; an ignored rd_valid pulse precedes the real response.
  task automatic respond(input int delay, input logic [63:0] d);
    rd_valid = 1'b1;
    rd_data  = ~d;
    step();
    rd_valid = 1'b0;
    repeat (delay) step();
    rd_valid = 1'b1;
    rd_data  = d;
    step();
    rd_valid = 1'b0;
    rd_data  = 64'h0;
  endtask

  task automatic wait_idle(input string tag, output int rx_bad);
    int n;
    n = 0;
    rx_bad = 0;
    @(negedge clk);
    while (busy && n < 1000) begin
      if (rx_ready) rx_bad++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    step();
  endtask

  function automatic logic expects_readback(input logic w, input logic [13:0] a);
    return !w && (a[13:12] == 2'b10 || a[13:12] == 2'b11);
  endfunction

  task automatic check_frame(input string tag, input int cb, input int tb0, input logic w,
                             input logic [13:0] a, input logic [63:0] d, input logic [63:0] rdat);
    int ntx;
    logic [7:0] eb;
    chk({tag, "_ncmd"}, 64'(mon_addr_q.size() - cb), 64'd1);
    if (mon_addr_q.size() > cb) begin
      chk({tag, "_wen"}, 64'(mon_wen_q[cb]), 64'(w));
      chk({tag, "_addr"}, 64'(mon_addr_q[cb]), 64'(a));
      if (w) chk({tag, "_data"}, mon_data_q[cb], d);
    end
    ntx = expects_readback(w, a) ? NB : 0;
    chk({tag, "_ntx"}, 64'(mon_tx_q.size() - tb0), 64'(ntx));
    for (int k = 0; k < ntx && tb0 + k < mon_tx_q.size(); k++) begin
      eb = 8'((rdat >> (8 * (NB - 1 - k))) & 64'hFF);
      chk($sformatf("%s_byte%0d", tag, k), 64'(mon_tx_q[tb0 + k]), 64'(eb));
    end
  endtask

  initial begin
    int          cb, tb0, rxb, n, exp_err;
    logic        w, rs, lw, have_w;
    logic [13:0] a, la;
    logic [63:0] d, rdat, ld;

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rd_valid = 1'b0; rd_data = 64'h0;
    lw = 1'b0; la = 14'h0; ld = 64'h0; have_w = 1'b0;
    exp_err = 0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_addr", 64'(cmd_addr), 64'd0);
    chk("rst_data", cmd_data, 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rx_ready", 64'(rx_ready), 64'd1);
    step();

    // write to addr 0x0123; byte0 carries wen in bit7 with the rsvd bit also set (0xC1)
    cb = mon_addr_q.size(); tb0 = mon_tx_q.size();
    send_frame(1'b1, 14'h0123, 64'h0102030405060708, 1'b1, 1'b0);
    chk("wr_cmd_valid_rise", 64'(cmd_valid), 64'd1);
    step();
    chk("wr_cmd_valid_fall", 64'(cmd_valid), 64'd0);
    wait_idle("wr", rxb);
    check_frame("wr", cb, tb0, 1'b1, 14'h0123, 64'h0102030405060708, 64'h0);

    // read 0x2010 with response four cycles after cmd_valid
    cb = mon_addr_q.size(); tb0 = mon_tx_q.size();
    send_frame(1'b0, 14'h2010, 64'h0, 1'b0, 1'b0);
    chk("rd_cmd_valid_rise", 64'(cmd_valid), 64'd1);
    chk("rd_rx_ready_issue", 64'(rx_ready), 64'd0);
    respond(3, 64'hA1B2C3D4E5F60718);
    wait_idle("rd", rxb);
    chk("rd_rx_ready_busy", 64'(rxb), 64'd0);
    check_frame("rd", cb, tb0, 1'b0, 14'h2010, 64'h0, 64'hA1B2C3D4E5F60718);

    // same read with tx_ready toggling
    txmode = 1;
    cb = mon_addr_q.size(); tb0 = mon_tx_q.size();
    send_frame(1'b0, 14'h2010, 64'h0, 1'b0, 1'b0);
    chk("rdst_rx_ready_issue", 64'(rx_ready), 64'd0);
    respond(3, 64'hA1B2C3D4E5F60718);
    wait_idle("rdst", rxb);
    chk("rdst_rx_ready_busy", 64'(rxb), 64'd0);
    check_frame("rdst", cb, tb0, 1'b0, 14'h2010, 64'h0, 64'hA1B2C3D4E5F60718);
    chk("rdst_stall_stable", 64'(stall_err), 64'd0);
    txmode = 0;

    // read to destination 00 returns nothing
    cb = mon_addr_q.size(); tb0 = mon_tx_q.size();
    send_frame(1'b0, 14'h0500, 64'h0, 1'b0, 1'b0);
    chk("d00_cmd_valid", 64'(cmd_valid), 64'd1);
    step(); step();
    chk("d00_busy_low", 64'(busy), 64'd0);
    chk("d00_rx_ready", 64'(rx_ready), 64'd1);
    repeat (5) step();
    check_frame("d00", cb, tb0, 1'b0, 14'h0500, 64'h0, 64'h0);

    // reset after 5 bytes of a write frame, then a full read frame
    cb = mon_addr_q.size();
    send_byte(8'hC1); send_byte(8'h23); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("mid_rst_data", cmd_data, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("mid_rst_no_cmd", 64'(mon_addr_q.size() - cb), 64'd0);
    cb = mon_addr_q.size(); tb0 = mon_tx_q.size();
    rdat = {$urandom, $urandom};
    send_frame(1'b0, 14'h3007, 64'h0, 1'b0, 1'b0);
    respond(1, rdat);
    wait_idle("rst_rd", rxb);
    check_frame("rst_rd", cb, tb0, 1'b0, 14'h3007, 64'h0, rdat);

    // reset in the middle of a readback
    txmode = 1;
    tb0 = mon_tx_q.size();
    send_frame(1'b0, 14'h2000, 64'h0, 1'b0, 1'b0);
    respond(0, 64'h1122334455667788);
    n = 0;
    @(negedge clk);
    while (mon_tx_q.size() < tb0 + 2 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("midtx_started", 64'(mon_tx_q.size() >= tb0 + 2), 64'd1);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midtx_rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("midtx_rst_tx_data", 64'(tx_data), 64'd0);
    step(); step();
    rst_n = 1'b1;
    cb = mon_addr_q.size(); tb0 = mon_tx_q.size();
    repeat (20) step();
    chk("midtx_no_residual_tx", 64'(mon_tx_q.size() - tb0), 64'd0);
    chk("midtx_no_cmd", 64'(mon_addr_q.size() - cb), 64'd0);
    chk("midtx_busy", 64'(busy), 64'd0);
    txmode = 0;

`ifdef UART_CMD_TIMEOUT_EN
    tb0 = mon_tx_q.size();
    send_frame(1'b0, 14'h3000, 64'h0, 1'b0, 1'b0);
    chk("to_cmd_valid", 64'(cmd_valid), 64'd1);
    step();
    repeat (14) step();
    chk("to_err_early", 64'(err_timeout), 64'd0);
    step();
    chk("to_err_pulse", 64'(err_timeout), 64'd1);
    chk("to_busy", 64'(busy), 64'd0);
    step();
    chk("to_err_one_cycle", 64'(err_timeout), 64'd0);
    repeat (5) step();
    chk("to_no_tx", 64'(mon_tx_q.size() - tb0), 64'd0);
    exp_err = 1;
`endif

    // randomized frames against the frame-level model
    for (int f = 0; f < 24; f++) begin
      w    = 1'($urandom_range(0, 1));
      a    = 14'($urandom);
      d    = {$urandom, $urandom};
      rdat = {$urandom, $urandom};
      rs   = 1'($urandom_range(0, 1));
      txmode = $urandom_range(0, 2);
      if (f > 0) begin
        chk("rnd_hold_wen", 64'(cmd_wen), 64'(lw));
        chk("rnd_hold_addr", 64'(cmd_addr), 64'(la));
        if (have_w) chk("rnd_hold_data", cmd_data, ld);
      end
      rd_valid = 1'b1; rd_data = ~rdat;
      step();
      rd_valid = 1'b0;
      cb = mon_addr_q.size(); tb0 = mon_tx_q.size();
      send_frame(w, a, d, rs, 1'b1);
      chk("rnd_cmd_valid", 64'(cmd_valid), 64'd1);
      if (expects_readback(w, a)) begin
        respond($urandom_range(0, 8), rdat);
      end else begin
        rd_valid = 1'b1; rd_data = rdat;
        step();
        rd_valid = 1'b0;
      end
      wait_idle($sformatf("rnd%0d", f), rxb);
      check_frame($sformatf("rnd%0d", f), cb, tb0, w, a, d, rdat);
      lw = w; la = a;
      if (w) begin
        ld = d;
        have_w = 1'b1;
      end
    end
    txmode = 0;
    repeat (3) step();

    chk("stall_stable_total", 64'(stall_err), 64'd0);
    chk("cmd_valid_single", 64'(wide_cmd), 64'd0);
    chk("err_timeout_count", 64'(err_cnt), 64'(exp_err));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
